rgbw_pwm: RTL

- Four-channel PWM output stage; reads the 8-bit red/green/blue/white duty words produced by the colour generator and drives the LED driver pins.
- Duty words are double-buffered: a write strobe captures them into a pending set, which becomes active only at a PWM period boundary, so outputs never glitch mid-period.
- A prescaler sets the PWM tick rate.

---
 rtl/rgbw_pwm.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/rgbw_pwm.sv
// Four-channel RGBW PWM output stage with double-buffered duty words and a tick prescaler.
// Optional build macro PWM_PHASE_STAGGER_EN staggers each channel's compare phase to spread inrush.
`timescale 1ns/1ps
module rgbw_pwm #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  dutyValid,
  input  logic [7:0]            redIn,
  input  logic [7:0]            greenIn,
  input  logic [7:0]            blueIn,
  input  logic [7:0]            whiteIn,
  output logic                  pwmRed,
  output logic                  pwmGreen,
  output logic                  pwmBlue,
  output logic                  pwmWhite,
  output logic                  periodStart,
  output logic                  updateAck
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic [PRESCALE_W-1:0]   latch_q, latch_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [3:0][7:0]         act_q, act_d;
  logic [3:0][7:0]         pend_q, pend_d;
  logic                    flag_q, flag_d;
  logic [3:0]              pwm_q, pwm_d;
  logic                    ps_q, ps_d;
  logic                    ack_q, ack_d;
  logic                    tick_s;
  logic [3:0][7:0]         phase_s;

`ifdef PWM_PHASE_STAGGER_EN
  // Channel order red, green, blue, white from index 0 upward.
  localparam logic [3:0][7:0] PHASE_OFFSET = {8'd192, 8'd128, 8'd64, 8'd0};

  function automatic logic [7:0] phase_of(input logic [7:0] c, input logic [7:0] off);
    logic [8:0] s;
    s = {1'b0, c} + {1'b0, off};
    if (s >= 9'd255) begin
      s = s - 9'd255;
    end else begin
      s = s;
    end
    return s[7:0];
  endfunction

  // Per-channel phase-shifted counter, kept inside the 0..254 range.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      phase_s[i] = phase_of(cnt_q, PHASE_OFFSET[i]);
    end
  end
`else
  // All channels share the period counter, so rising edges align at periodStart.
  always_comb begin
    phase_s = {4{cnt_q}};
  end
`endif

  // Next-state logic: idle/run sequencing, period boundary, pending-set transfer and capture.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    latch_d = latch_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    pend_d  = pend_q;
    flag_d  = flag_q;
    pwm_d   = 4'b0000;
    ps_d    = 1'b0;
    ack_d   = 1'b0;
    tick_s  = (presc_q == latch_q);
    case (state_q)
      IDLE: begin
        presc_d = '0;
        cnt_d   = 8'd0;
        latch_d = prescale;
        if (flag_q) begin
          act_d  = pend_q;
          flag_d = 1'b0;
          ack_d  = 1'b1;
        end else begin
          ack_d  = 1'b0;
        end
        if (enable) begin
          state_d = RUN;
          ps_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          presc_d = '0;
          cnt_d   = 8'd0;
        end else begin
          for (int i = 0; i < 4; i++) begin
            pwm_d[i] = (phase_s[i] < act_q[i]);
          end
          if (tick_s) begin
            presc_d = '0;
            // Period boundary: duties and tick rate only change here.
            if (cnt_q == 8'd254) begin
              cnt_d   = 8'd0;
              latch_d = prescale;
              ps_d    = 1'b1;
              if (flag_q) begin
                act_d  = pend_q;
                flag_d = 1'b0;
                ack_d  = 1'b1;
              end else begin
                ack_d  = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            presc_d = presc_q + PRESCALE_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
        cnt_d   = 8'd0;
      end
    endcase
    // A fresh capture overrides any clear from the transfer above.
    if (dutyValid) begin
      pend_d = {whiteIn, blueIn, greenIn, redIn};
      flag_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      latch_q <= '0;
      cnt_q   <= 8'd0;
      act_q   <= '0;
      pend_q  <= '0;
      flag_q  <= 1'b0;
      pwm_q   <= 4'b0000;
      ps_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      flag_q  <= flag_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
      ack_q   <= ack_d;
    end
  end

  assign pwmRed      = pwm_q[0];
  assign pwmGreen    = pwm_q[1];
  assign pwmBlue     = pwm_q[2];
  assign pwmWhite    = pwm_q[3];
  assign periodStart = ps_q;
  assign updateAck   = ack_q;

endmodule
